neuron_output_collector: RTL and testbench
==========================================

Name: neuron_output_collector

Overview:
- Consumer end of the neuron result interface. Accepts the valid-qualified 23-bit accumulator results produced by a neuron layer.
- Applies ReLU, a fixed-point rescale and saturation, and buffers one full vector of results.
- Replays the vector as a contiguous valid-qualified 12-bit stream, one word per cycle, in the format the next neuron layer's multiplicand input expects.
- Sits between two neuron layers.

Parameters:
- IN_W, 23, width of incoming accumulator result (signed two's complement)
- OUT_W, 12, width of outgoing multiplicand word (unsigned after ReLU)
- FRAC_SHIFT, 8, right shift applied to rescale accumulator fraction bits to output format
- VEC_LEN, 3, results per vector (buffer depth / burst length), >=1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data valid this cycle
- in_data  in  IN_W  signed accumulator result
- out_ready  in  1  downstream layer can accept a full burst
- out_valid  out  1  out_data valid this cycle
- out_data  out  OUT_W  quantized multiplicand word
- out_last  out  1  marks final word of burst
- busy  out  1  high in WAIT or SEND
- drop_err  out  1  sticky; an input arrived while not collecting

Behaviour:
- Reset (rst=0, async): state=COLLECT, wr_cnt=0, rd_cnt=0, out_valid=0, out_data=0, out_last=0, busy=0, drop_err=0. Buffer contents don't care.
- Reset mid-burst aborts immediately. Outputs go to reset values without waiting for a clock edge, and the partial vector is discarded.
- Quantize (combinational, on in_data):
  - If in_data[IN_W-1]=1 (negative), q=0.
  - Else s = in_data >> FRAC_SHIFT (logical shift on a non-negative value), and q = (s > 2^OUT_W-1) ? 2^OUT_W-1 : s[OUT_W-1:0].
- State COLLECT:
  - Each edge with in_valid=1 writes q to buf[wr_cnt] and increments wr_cnt.
  - When the write lands at wr_cnt=VEC_LEN-1, wr_cnt wraps to 0 and state goes to WAIT.
  - in_valid=0 leaves everything unchanged.
  - Gaps between input words are allowed.
- State WAIT:
  - busy=1.
  - On an edge with out_ready=1: state goes to SEND, rd_cnt=1, out_valid=1, out_data=buf[0], and out_last=(VEC_LEN==1).
  - Minimum latency: the last input is sampled at edge k, WAIT holds during cycle k..k+1, and the first out_valid is registered at edge k+1.
- State SEND:
  - busy=1.
  - Each edge registers out_data=buf[rd_cnt], out_valid=1, out_last=(rd_cnt==VEC_LEN-1), then rd_cnt++.
  - The edge following the out_last word clears out_valid and out_last, sets state to COLLECT, rd_cnt=0 and busy=0.
  - out_data holds its last value when out_valid=0.
  - Once started, the burst is exactly VEC_LEN consecutive cycles. out_ready is ignored in SEND.
- in_valid=1 in WAIT or SEND: the word is dropped, the buffer is not modified and drop_err is set.
  - drop_err clears only on reset.
- Same-edge ordering: on the SEND-to-COLLECT edge the state is still SEND, so an in_valid on that edge is dropped and sets drop_err.
  - The first word accepted is the one on the following edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset then in_valid for 3 cycles with in_data=0x000A00, 0x001800, 0x000100; out_ready=1 → two edges later out_valid high for 3 consecutive cycles with out_data=10, 24, 1; out_last only on the third word.
- Vector 0x7FFFFF (-1), 0x400000 (most negative), 0x0000FF; out_ready=1 → out_data=0, 0, 0 (ReLU and truncation).
- Vector 0x3FFFFF, 0x0FFF00, 0x100000 → out_data=4095 (saturated), 4095 (exact 0xFFF), 4095 (4096 saturated).
- Vector loaded with out_ready=0 for 5 cycles → out_valid stays 0 and busy=1. Raise out_ready → burst starts on the next edge. An in_valid pulse during WAIT sets drop_err=1 and the burst data is unchanged.
- Inputs with gaps (in_valid 1,0,0,1,0,1) collect correctly. A second vector sent immediately after the burst ends emits a correct second burst.
- Drive rst=0 asynchronously during the 2nd SEND cycle → out_valid, out_last and busy drop immediately. After release, a new 3-word vector produces a normal burst.

Source files
------------

// File: rtl/neuron_output_collector.sv
// ---------------------------------------------------------------------------
// neuron_output_collector
//
// Consumer end of a neuron layer's result interface. Each valid accumulator
// result is passed through ReLU, rescaled by a right shift and saturated to
// an unsigned multiplicand word. The words are buffered until a full vector
// is held, and the vector is then replayed to the next layer as one burst.
// The burst is contiguous, valid-qualified and one word per cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   in_valid   in_data carries a result this cycle
//   in_data    signed accumulator result (IN_W bits, two's complement)
//   out_ready  downstream can take a whole burst; sampled only while waiting
//   out_valid  out_data carries a word this cycle
//   out_data   quantized multiplicand word (OUT_W bits, unsigned)
//   out_last   final word of the burst
//   busy       a full vector is held (waiting to send or sending)
//   drop_err   sticky: a result arrived while a vector was held
// ---------------------------------------------------------------------------
module neuron_output_collector #(
    parameter int IN_W       = 23,
    parameter int OUT_W      = 12,
    parameter int FRAC_SHIFT = 8,
    parameter int VEC_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             drop_err
);

    // The read counter steps one past the last index after the final word,
    // so the counters must be able to hold VEC_LEN itself.
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [IN_W-1:0]  SAT_MAX  = IN_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   wr_cnt_reg;
    logic [CNT_W-1:0]   rd_cnt_reg;
    logic               out_valid_reg;
    logic [OUT_W-1:0]   out_data_reg;
    logic               out_last_reg;
    logic               busy_reg;
    logic               drop_err_reg;

    // Vector buffer. It is never reset; its contents only matter after a
    // complete vector has been written.
    logic [OUT_W-1:0]   buf_mem [0:VEC_LEN-1];

    // ---------------------------------------------------------------
    // Quantizer: ReLU, then shift out the fraction bits, then clamp.
    // The shift is applied to the raw vector, so it is logical. That is
    // safe because negative inputs never reach the clamp.
    // ---------------------------------------------------------------
    logic [IN_W-1:0]  shifted;
    logic [OUT_W-1:0] q_word;

    assign shifted = in_data >> FRAC_SHIFT;

    always_comb begin
        q_word = '0;
        if (!in_data[IN_W-1]) begin
            q_word = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
        end
    end

    // Results are accepted only while collecting; anything else is dropped.
    logic wr_en;
    assign wr_en = in_valid && (state_reg == ST_COLLECT);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt_reg] <= q_word;
        end
    end

    // WAIT launches the burst with word 0; SEND walks the read counter.
    logic [CNT_W-1:0] rd_addr;
    assign rd_addr = (state_reg == ST_SEND) ? rd_cnt_reg : '0;

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_COLLECT;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            drop_err_reg  <= 1'b0;
        end else begin
            // A result is dropped whenever a vector is held. This includes
            // the edge that closes a burst, because the state is still SEND
            // on that edge.
            if (in_valid && (state_reg != ST_COLLECT)) begin
                drop_err_reg <= 1'b1;
            end

            case (state_reg)
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (wr_cnt_reg == LAST_IDX) begin
                            wr_cnt_reg <= '0;
                            state_reg  <= ST_WAIT;
                            busy_reg   <= 1'b1;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (out_ready) begin
                        state_reg     <= ST_SEND;
                        rd_cnt_reg    <= CNT_W'(1);
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= buf_mem[rd_addr];
                        out_last_reg  <= (VEC_LEN == 1);
                    end
                end

                ST_SEND: begin
                    if (out_last_reg) begin
                        // The burst is complete. out_data keeps its last
                        // word.
                        state_reg     <= ST_COLLECT;
                        rd_cnt_reg    <= '0;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= buf_mem[rd_addr];
                        out_last_reg  <= (rd_cnt_reg == LAST_IDX);
                        rd_cnt_reg    <= rd_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_COLLECT;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign drop_err  = drop_err_reg;

endmodule

// File: tb/tb_neuron_output_collector.sv
// ---------------------------------------------------------------------------
// tb_neuron_output_collector
//
// Directed testbench for neuron_output_collector.
//
// A transaction-level model predicts every output on every cycle. It keeps
// the words being collected and the held burst in queues, and it quantizes
// with plain integer arithmetic. A per-cycle compare process checks the DUT
// against the model. The directed sequences also check hand-computed burst
// words and latencies.
// ---------------------------------------------------------------------------
module tb_neuron_output_collector;

    localparam int IN_W    = 23;
    localparam int OUT_W   = 12;
    localparam int VEC_LEN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             drop_err;

    int n_vec = 0;
    int n_err = 0;

    neuron_output_collector #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (8),
        .VEC_LEN    (VEC_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int quant(input logic [IN_W-1:0] d);
        int v;
        if (d[IN_W-1]) return 0;           // ReLU
        v = int'(d) / 256;                 // drop 8 fraction bits
        return (v > 4095) ? 4095 : v;      // clamp to 12-bit unsigned
    endfunction

    int coll_q[$];
    int burst_q[$];
    bit m_hold, m_send;
    int m_pos;
    bit e_valid, e_last, e_busy, e_drop;
    int e_data;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                coll_q.delete();
                burst_q.delete();
                m_hold = 0; m_send = 0; m_pos = 0;
                e_valid = 0; e_last = 0; e_busy = 0; e_drop = 0; e_data = 0;
            end else if (!m_hold) begin
                if (in_valid) begin
                    coll_q.push_back(quant(in_data));
                    if (coll_q.size() == VEC_LEN) begin
                        burst_q = coll_q;
                        coll_q.delete();
                        m_hold = 1;
                        e_busy = 1;
                    end
                end
            end else begin
                if (in_valid) e_drop = 1;
                if (!m_send) begin
                    if (out_ready) begin
                        m_send = 1;
                        e_valid = 1;
                        e_data = burst_q[0];
                        e_last = (VEC_LEN == 1);
                        m_pos = 1;
                    end
                end else if (m_pos == VEC_LEN) begin
                    e_valid = 0; e_last = 0; e_busy = 0;
                    m_hold = 0; m_send = 0;
                    burst_q.delete();
                end else begin
                    e_valid = 1;
                    e_data = burst_q[m_pos];
                    e_last = (m_pos == VEC_LEN - 1);
                    m_pos++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if ($time > 2) begin
                chk("cyc_out_valid", 32'(out_valid), 32'(e_valid));
                chk("cyc_out_last",  32'(out_last),  32'(e_last));
                chk("cyc_busy",      32'(busy),      32'(e_busy));
                chk("cyc_drop_err",  32'(drop_err),  32'(e_drop));
                chk("cyc_out_data",  32'(out_data),  32'(e_data));
                if (out_valid)
                    $display("out word %0d last=%0b at %0t", out_data, out_last, $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [IN_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("in word 0x%06h at %0t", d, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Call one edge before the burst starts (out_ready high, vector held).
    // If inj is set, a result is presented on the edge that closes the burst.
    task automatic check_burst(input int w0, input int w1, input int w2, input bit inj);
        @(posedge clk); #1;
        chk("b0_valid", 32'(out_valid), 1); chk("b0_data", 32'(out_data), 32'(w0));
        chk("b0_last", 32'(out_last), 0);   chk("b0_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("b1_valid", 32'(out_valid), 1); chk("b1_data", 32'(out_data), 32'(w1));
        chk("b1_last", 32'(out_last), 0);
        @(posedge clk); #1;
        chk("b2_valid", 32'(out_valid), 1); chk("b2_data", 32'(out_data), 32'(w2));
        chk("b2_last", 32'(out_last), 1);
        if (inj) begin in_valid = 1'b1; in_data = 23'h007700; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bend_valid", 32'(out_valid), 0); chk("bend_last", 32'(out_last), 0);
        chk("bend_busy", 32'(busy), 0);       chk("bend_hold", 32'(out_data), 32'(w2));
        if (inj) chk("bend_drop_err", 32'(drop_err), 1);
        $display("burst %0d %0d %0d done at %0t", w0, w1, w2, $time);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst = 1'b0;
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_drop_err",  32'(drop_err),  0);
        rst = 1'b1;
        out_ready = 1'b1;

        // Basic vector, minimum latency
        push(23'h000A00); push(23'h001800); push(23'h000100);
        chk("t1_busy_wait", 32'(busy), 1);
        chk("t1_no_valid_yet", 32'(out_valid), 0);
        check_burst(10, 24, 1, 0);

        // ReLU and truncation
        push(23'h7FFFFF); push(23'h400000); push(23'h0000FF);
        check_burst(0, 0, 0, 0);

        // Saturation boundaries
        push(23'h3FFFFF); push(23'h0FFF00); push(23'h100000);
        check_burst(4095, 4095, 4095, 0);

        // Held in WAIT, drop while waiting
        out_ready = 1'b0;
        push(23'h005000); push(23'h002300); push(23'h000000);
        repeat (5) begin
            idle(1);
            chk("t4_wait_busy", 32'(busy), 1);
            chk("t4_wait_valid", 32'(out_valid), 0);
        end
        push(23'h007F00);
        chk("t4_drop_err", 32'(drop_err), 1);
        out_ready = 1'b1;
        check_burst(80, 35, 0, 0);

        // Gapped input, then a back-to-back second vector
        push(23'h000C00); idle(2); push(23'h000D00); idle(1); push(23'h000E00);
        check_burst(12, 13, 14, 0);
        push(23'h002000); push(23'h003000); push(23'h000010);
        check_burst(32, 48, 0, 0);

        // Asynchronous reset during the 2nd SEND cycle
        push(23'h000100); push(23'h000200); push(23'h000300);
        @(posedge clk); #1;
        chk("t6_first_word", 32'(out_data), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_last",  32'(out_last),  0);
        chk("t6_async_busy",  32'(busy),      0);
        chk("t6_async_drop",  32'(drop_err),  0);
        chk("t6_async_data",  32'(out_data),  0);
        @(posedge clk); #1;
        rst = 1'b1;
        push(23'h000400); push(23'h000500); push(23'h000600);
        check_burst(4, 5, 6, 1);
        // The word presented on the closing edge must not enter the next vector
        push(23'h000700); push(23'h000800); push(23'h000900);
        check_burst(7, 8, 9, 0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
